wb_uart_tx_scheduler: RTL and testbench

- Wishbone master that shares the UART transmitter between two byte-stream requesters.
- Round-robin arbitrates requester pushes into an internal FIFO.
- Polls the UART control register for TX-empty, then writes the FIFO head to the UART TX register.
- Sits between on-chip producers (debug monitor, console) and the bus, so CPU software never polls the UART.

---
 rtl/wb_uart_tx_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_wb_uart_tx_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_tx_scheduler.sv
// Wishbone master that shares one UART transmitter between two byte-stream
// requesters. Pushes are round-robin arbitrated into a FIFO. The FIFO head is
// sent by polling the UART control register for TX-empty and then writing the
// byte to the TX register.
//
// Requester handshake: a byte transfers on the rising edge where reqN_valid
// and reqN_ready are both high. Ready is combinational:
// valid & grant & !full. At most one requester is accepted per cycle.
// Valid may be raised at any time. Data must be held while valid is high and
// ready is low.
module wb_uart_tx_scheduler #(
  parameter logic [31:0] UART_BASE  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          TXE_BIT    = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_req0_valid,
  input  logic [8:0]                    i_req0_data,
  output logic                          o_req0_ready,
  input  logic                          i_req1_valid,
  input  logic [8:0]                    i_req1_data,
  output logic                          o_req1_ready,
  output logic                          o_wb_cyc,
  output logic                          o_wb_stb,
  output logic                          o_wb_we,
  output logic [31:0]                   o_wb_addr,
  output logic [31:0]                   o_wb_data,
  output logic [3:0]                    o_wb_sel,
  output logic [2:0]                    o_wb_cti,
  input  logic                          i_wb_ack,
  input  logic                          i_wb_err,
  input  logic [31:0]                   i_wb_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_busy,
  output logic                          o_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POLL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // The FSM state is kept as a named signal so checkers can bind to it.
  state_t state;
  state_t state_next;

  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [8:0]  push_data;
  logic [8:0]  head;
  logic        rr_ptr;
  logic        grant0;
  logic        grant1;
  logic        unused_rd_bits;

  // Only the TX-empty bit of the read data is used.
  assign unused_rd_bits = ^i_wb_data;

  // The wrap bit tells full apart from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A lone requester always wins. On a tie, rr_ptr picks the winner
  // (0 selects requester 0).
  assign grant0 = i_req0_valid & (~i_req1_valid | ~rr_ptr);
  assign grant1 = i_req1_valid & (~i_req0_valid |  rr_ptr);

  assign o_req0_ready = grant0 & ~full;
  assign o_req1_ready = grant1 & ~full;
  assign push         = o_req0_ready | o_req1_ready;
  assign push_data    = o_req0_ready ? i_req0_data : i_req1_data;

  assign o_level  = wr_ptr - rd_ptr;
  assign o_busy   = ~empty | o_wb_cyc;
  assign o_wb_sel = 4'hF;
  assign o_wb_cti = 3'b000;

  // After each accepted push, priority moves to the other requester.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr <= 1'b0;
    end else if (push) begin
      rr_ptr <= o_req0_ready;
    end
  end

  // FIFO storage is written at the push edge. It is not reset because the
  // pointers define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // FIFO pointers: a push and a pop in the same cycle both take effect.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Sticky bus-error flag. Only reset clears it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if (o_wb_cyc && i_wb_err) begin
      o_err <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and bus outputs. Outputs depend only on the state, so
  // they hold steady for the whole strobe. Leaving POLL or WRITE on ack or err
  // drops cyc/stb at that same edge. err takes priority over ack, and the
  // head is then kept for a retry.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    o_wb_cyc   = 1'b0;
    o_wb_stb   = 1'b0;
    o_wb_we    = 1'b0;
    o_wb_addr  = 32'h0;
    o_wb_data  = 32'h0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_next = POLL;
        end
      end
      POLL: begin
        o_wb_cyc  = 1'b1;
        o_wb_stb  = 1'b1;
        o_wb_addr = UART_BASE;
        if (i_wb_err) begin
          state_next = IDLE;
        end else if (i_wb_ack) begin
          state_next = i_wb_data[TXE_BIT] ? WRITE : IDLE;
        end
      end
      WRITE: begin
        o_wb_cyc  = 1'b1;
        o_wb_stb  = 1'b1;
        o_wb_we   = 1'b1;
        o_wb_addr = UART_BASE + 32'h8;
        o_wb_data = {23'b0, head};
        if (i_wb_err) begin
          state_next = IDLE;
        end else if (i_wb_ack) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_uart_tx_scheduler.sv
// Directed bench for wb_uart_tx_scheduler. A Wishbone slave model answers
// CR reads from a queue of TX-empty values and checks every write against
// an expected queue. The main sequence drives the requesters and checks
// levels, readies and flags.
module tb_wb_uart_tx_scheduler;

  localparam logic [31:0] BASE = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        v0 = 1'b0;
  logic [8:0]  d0 = '0;
  logic        r0;
  logic        v1 = 1'b0;
  logic [8:0]  d1 = '0;
  logic        r1;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic        ack = 1'b0;
  logic        berr = 1'b0;
  logic [31:0] rdata = '0;
  logic [4:0]  level;
  logic        busy;
  logic        err;

  wb_uart_tx_scheduler #(
    .UART_BASE  (BASE),
    .FIFO_DEPTH (16),
    .TXE_BIT    (2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req0_valid (v0),
    .i_req0_data  (d0),
    .o_req0_ready (r0),
    .i_req1_valid (v1),
    .i_req1_data  (d1),
    .o_req1_ready (r1),
    .o_wb_cyc     (cyc),
    .o_wb_stb     (stb),
    .o_wb_we      (we),
    .o_wb_addr    (addr),
    .o_wb_data    (wdata),
    .o_wb_sel     (sel),
    .o_wb_cti     (cti),
    .i_wb_ack     (ack),
    .i_wb_err     (berr),
    .i_wb_data    (rdata),
    .o_level      (level),
    .o_busy       (busy),
    .o_err        (err)
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic        cr_q[$];
  int          n_rd = 0;
  int          n_wr = 0;
  logic        default_txe = 1'b1;
  logic        stall_rd = 1'b0;
  logic        stall_wr = 1'b0;
  logic        err_on_wr = 1'b0;
  logic        slv_txe;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- Wishbone slave model ----------------
  // Responses are set on the falling edge and are seen at the next rising
  // edge. The DUT drops the strobe on that edge, so each transfer is served
  // once.
  always @(negedge clk) begin
    ack   = 1'b0;
    berr  = 1'b0;
    rdata = 32'h0;
    if (!rst && cyc && stb) begin
      check("sel", 32'(sel), 32'hF);
      check("cti", 32'(cti), 32'h0);
      if (!we) begin
        if (!stall_rd) begin
          check("rd_addr", addr, BASE);
          slv_txe = (cr_q.size() != 0) ? cr_q.pop_front() : default_txe;
          rdata   = slv_txe ? 32'h0000_0004 : 32'hFFFF_FFFB;
          n_rd++;
          ack = 1'b1;
        end
      end else if (!stall_wr) begin
        check("wr_addr", addr, BASE + 32'h8);
        if (err_on_wr) begin
          berr      = 1'b1;
          err_on_wr = 1'b0;
        end else begin
          check("wr_pending", 32'(exp_q.size() != 0), 32'h1);
          if (exp_q.size() != 0) check("wr_data", wdata, exp_q.pop_front());
          n_wr++;
          ack = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    v0  = 1'b0;
    v1  = 1'b0;
    cr_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic push_one(input int req, input logic [8:0] d);
    int k;
    logic rdy;
    k = 0;
    if (req == 0) begin v0 = 1'b1; d0 = d; end
    else          begin v1 = 1'b1; d1 = d; end
    #1;
    rdy = (req == 0) ? r0 : r1;
    while (!rdy && k < 20) begin
      @(negedge clk);
      #1;
      rdy = (req == 0) ? r0 : r1;
      k++;
    end
    check("push_rdy", 32'(rdy), 32'h1);
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("idle_to", 32'(busy), 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int rd0;
    int wr0;
    int i0;
    int i1;
    int acc;
    int k;
    logic got;

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_cyc",   32'(cyc),   32'h0);
    check("rst_stb",   32'(stb),   32'h0);
    check("rst_we",    32'(we),    32'h0);
    check("rst_addr",  addr,       32'h0);
    check("rst_data",  wdata,      32'h0);
    check("rst_sel",   32'(sel),   32'hF);
    check("rst_cti",   32'(cti),   32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_err",   32'(err),   32'h0);
    check("rst_rdy0",  32'(r0),    32'h0);
    check("rst_rdy1",  32'(r1),    32'h0);
    rst = 1'b0;

    // Test 1: a single byte is sent as one CR poll followed by one TX write.
    @(negedge clk);
    rd0 = n_rd;
    wr0 = n_wr;
    exp_q.push_back(32'h0000_0041);
    push_one(0, 9'h041);
    check("t1_level1", 32'(level), 32'h1);
    check("t1_busy1",  32'(busy),  32'h1);
    wait_idle(30);
    check("t1_level0", 32'(level), 32'h0);
    check("t1_reads",  32'(n_rd - rd0), 32'h1);
    check("t1_writes", 32'(n_wr - wr0), 32'h1);

    // Test 2: both requesters hold valid, so grants alternate starting with req0.
    do_reset();
    stall_rd = 1'b1;
    exp_q.push_back(32'h10); exp_q.push_back(32'h20);
    exp_q.push_back(32'h11); exp_q.push_back(32'h21);
    exp_q.push_back(32'h12); exp_q.push_back(32'h22);
    exp_q.push_back(32'h13); exp_q.push_back(32'h23);
    wr0 = n_wr;
    i0  = 0;
    i1  = 0;
    for (int c = 0; c < 8; c++) begin
      v0 = (i0 < 4);
      d0 = 9'h010 + 9'(i0);
      v1 = (i1 < 4);
      d1 = 9'h020 + 9'(i1);
      #1;
      check("t2_rdy0", 32'(r0), 32'((c % 2) == 0));
      check("t2_rdy1", 32'(r1), 32'((c % 2) == 1));
      if (r0) i0++;
      if (r1) i1++;
      @(negedge clk);
    end
    v0 = 1'b0;
    v1 = 1'b0;
    #1;
    check("t2_level8", 32'(level), 32'h8);
    stall_rd = 1'b0;
    wait_idle(100);
    check("t2_level0", 32'(level), 32'h0);
    check("t2_writes", 32'(n_wr - wr0), 32'h8);

    // Test 3: three CR reads report not-empty, then one write follows.
    do_reset();
    cr_q.push_back(1'b0);
    cr_q.push_back(1'b0);
    cr_q.push_back(1'b0);
    rd0 = n_rd;
    wr0 = n_wr;
    exp_q.push_back(32'h0000_0155);
    push_one(1, 9'h155);
    wait_idle(60);
    check("t3_reads",  32'(n_rd - rd0), 32'h4);
    check("t3_writes", 32'(n_wr - wr0), 32'h1);
    check("t3_level0", 32'(level), 32'h0);

    // Test 4: fill the FIFO while TX is never empty, then allow one write.
    do_reset();
    default_txe = 1'b0;
    wr0 = n_wr;
    exp_q.push_back(32'h0000_0080);
    acc = 0;
    k   = 0;
    v0  = 1'b1;
    while (acc < 16 && k < 60) begin
      d0 = 9'h080 + 9'(acc);
      #1;
      if (r0) acc++;
      k++;
      @(negedge clk);
    end
    d0 = 9'h0F0;
    v1 = 1'b1;
    d1 = 9'h0F1;
    #1;
    check("t4_level16", 32'(level), 32'd16);
    check("t4_rdy0",    32'(r0),    32'h0);
    check("t4_rdy1",    32'(r1),    32'h0);
    cr_q.push_back(1'b1);
    got = 1'b0;
    k   = 0;
    while (!got && k < 60) begin
      @(negedge clk);
      #1;
      if (level == 5'd16) check("t4_full_rdy", 32'(r0 | r1), 32'h0);
      else if (r0 | r1) got = 1'b1;
      k++;
    end
    check("t4_accept", 32'(got), 32'h1);
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
    #1;
    check("t4_refill",  32'(level), 32'd16);
    check("t4_writes",  32'(n_wr - wr0), 32'h1);

    // Test 5: a write ended by err sets the sticky flag, and the byte is retried.
    do_reset();
    default_txe = 1'b1;
    err_on_wr   = 1'b1;
    rd0 = n_rd;
    wr0 = n_wr;
    exp_q.push_back(32'h0000_0077);
    push_one(0, 9'h077);
    k = 0;
    while (!err && k < 30) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("t5_err_set",  32'(err),   32'h1);
    check("t5_level1",   32'(level), 32'h1);
    wait_idle(40);
    check("t5_err_hold", 32'(err),   32'h1);
    check("t5_level0",   32'(level), 32'h0);
    check("t5_reads",    32'(n_rd - rd0), 32'h2);
    check("t5_writes",   32'(n_wr - wr0), 32'h1);

    // Test 6: reset during a stalled write drops the cycle and clears all state.
    stall_wr = 1'b1;
    push_one(1, 9'h033);
    k = 0;
    while (!(cyc && we) && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("t6_we",    32'(we),   32'h1);
    check("t6_addr",  addr,      BASE + 32'h8);
    check("t6_data",  wdata,     32'h0000_0033);
    @(negedge clk);
    #1;
    check("t6_stb_hold",  32'(stb), 32'h1);
    check("t6_data_hold", wdata,    32'h0000_0033);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t6_cyc",   32'(cyc),   32'h0);
    check("t6_stb",   32'(stb),   32'h0);
    check("t6_level", 32'(level), 32'h0);
    check("t6_err",   32'(err),   32'h0);
    check("t6_busy",  32'(busy),  32'h0);
    rst      = 1'b0;
    stall_wr = 1'b0;
    @(negedge clk);
    @(negedge clk);

    check("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
